// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_CLEANUP
  } rx_state_t;

  // One extra bit of headroom so CLKS_PER_BIT-1 always fits with room to spare.
  function automatic int clk_cnt_width(input int cpb);
    return $clog2(cpb) + 1;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchroniser for an asynchronous level input; flops reset to 1
// so an idle-high line never looks like an edge on reset release.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_d,
  output logic o_q
);

  if (STAGES < 2) begin : g_stages_chk
    $fatal(1, "uart_rx_sync: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], i_d};

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) sync_q <= '1;
    else         sync_q <= sync_d;
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling off a synchronised line.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote on every data and stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam int CW = clk_cnt_width(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

`ifdef UART_RX_MAJORITY_EN
  if (CLKS_PER_BIT < 4) begin : g_cpb_chk
    $fatal(1, "uart_rx: CLKS_PER_BIT must be >= 4 with majority voting");
  end
`else
  if (CLKS_PER_BIT < 2) begin : g_cpb_chk
    $fatal(1, "uart_rx: CLKS_PER_BIT must be >= 2");
  end
`endif

  rx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             active_q, active_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;
  logic             bit_done;
  logic             bit_val;

  uart_rx_sync #(.STAGES(2)) u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_d     (i_Rx_Serial),
    .o_q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Votes at LAST-1 and LAST; the third sample and the decision land on the
  // cycle after the counter wraps, so the bit period itself is untouched.
  logic [1:0] vote_q, vote_d;
  logic       pend_q, pend_d;

  assign bit_done = pend_q;
  assign bit_val  = maj3(vote_q[0], vote_q[1], rx_s);

  always_comb begin
    vote_d = vote_q;
    pend_d = 1'b0;
    if (state_q == RX_DATA || state_q == RX_STOP) begin
      if (cnt_q == LAST - CNT_ONE) vote_d[0] = rx_s;
      if (cnt_q == LAST) begin
        vote_d[1] = rx_s;
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      vote_q <= '0;
      pend_q <= 1'b0;
    end else begin
      vote_q <= vote_d;
      pend_q <= pend_d;
    end
  end
`else
  assign bit_done = (cnt_q == LAST);
  assign bit_val  = rx_s;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    active_d = active_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d  = RX_DATA;
            active_d = 1'b1;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_ONE;
        if (bit_done) begin
          shift_d[idx_q] = bit_val;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = RX_STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      RX_STOP: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_ONE;
        if (bit_done) begin
          if (bit_val) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          active_d = 1'b0;
          cnt_d    = '0;
          state_d  = RX_CLEANUP;
        end
      end
      RX_CLEANUP: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Active    = active_q;
  assign o_Rx_Frame_Err = ferr_q;

endmodule
